// File: rtl/hamming_dual_decoder_pkg.sv
// Shared constants and types for the dual Hamming(7,4) decoder.
package hd_pkg;

   // Code-word geometry
   localparam int unsigned CW_W   = 7;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned RES_W  = 6;

   // Bit positions inside a code word, MSB first: p1 p2 p3 x1 x2 x3 x4
   localparam int unsigned P1 = 6;
   localparam int unsigned P2 = 5;
   localparam int unsigned P3 = 4;
   localparam int unsigned X1 = 3;
   localparam int unsigned X2 = 2;
   localparam int unsigned X3 = 1;
   localparam int unsigned X4 = 0;

   // Operation selected by {eb1, eb2}
   localparam logic [1:0] OP_2A_PLUS_B  = 2'b00;
   localparam logic [1:0] OP_2A_MINUS_B = 2'b01;
   localparam logic [1:0] OP_A_MINUS_2B = 2'b10;
   localparam logic [1:0] OP_A_PLUS_2B  = 2'b11;

   typedef logic        [CW_W-1:0]   code_word_t;
   typedef logic signed [DATA_W-1:0] data_t;
   typedef logic signed [RES_W-1:0]  result_t;

endpackage

// File: rtl/hamming_dual_decoder_corrector.sv
// Combinational single-error corrector for one Hamming(7,4) code word.
module hamming74_corrector
   import hd_pkg::*;
(
   input  code_word_t i_code_word,
   output data_t      o_data,
   output logic       o_eb
);

   logic [2:0] w_syndrome;
   code_word_t w_mask;
   code_word_t w_corrected;

   // Syndrome, error-position mask and correction
   always_comb begin
      w_syndrome = '0;
      w_mask     = '0;
      w_syndrome[2] = i_code_word[P1] ^ i_code_word[X1] ^ i_code_word[X2] ^ i_code_word[X3];
      w_syndrome[1] = i_code_word[P2] ^ i_code_word[X1] ^ i_code_word[X2] ^ i_code_word[X4];
      w_syndrome[0] = i_code_word[P3] ^ i_code_word[X1] ^ i_code_word[X3] ^ i_code_word[X4];
      case (w_syndrome)
         3'b100:  w_mask[P1] = 1'b1;
         3'b010:  w_mask[P2] = 1'b1;
         3'b001:  w_mask[P3] = 1'b1;
         3'b111:  w_mask[X1] = 1'b1;
         3'b110:  w_mask[X2] = 1'b1;
         3'b101:  w_mask[X3] = 1'b1;
         3'b011:  w_mask[X4] = 1'b1;
         default: w_mask     = '0;   // syndrome 000: nothing to correct
      endcase
      w_corrected = i_code_word ^ w_mask;
   end

   // eb is the received value of the bit that was wrong (0 when no error)
   assign o_eb   = |(i_code_word & w_mask);
   assign o_data = data_t'({w_corrected[X1], w_corrected[X2], w_corrected[X3], w_corrected[X4]});

endmodule

// File: rtl/hamming_dual_decoder.sv
// Corrects two Hamming(7,4) words and combines their data; one registered stage.
module hamming_dual_decoder
   import hd_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [CW_W-1:0] code_word1,
   input  logic [CW_W-1:0] code_word2,
   output logic            out_valid,
   output logic [RES_W-1:0] out_n
);

   data_t   w_c1;
   data_t   w_c2;
   logic    w_eb1;
   logic    w_eb2;
   result_t w_a;
   result_t w_b;
   result_t w_result;

   logic            r_out_valid;
   result_t         r_out_n;

   hamming74_corrector u_corr1 (
      .i_code_word (code_word_t'(code_word1)),
      .o_data      (w_c1),
      .o_eb        (w_eb1)
   );

   hamming74_corrector u_corr2 (
      .i_code_word (code_word_t'(code_word2)),
      .o_data      (w_c2),
      .o_eb        (w_eb2)
   );

   // Sign-extend both data, then apply the operation chosen by the erroneous bits
   always_comb begin
      w_a      = result_t'(w_c1);
      w_b      = result_t'(w_c2);
      w_result = '0;
      case ({w_eb1, w_eb2})
         OP_2A_PLUS_B:  w_result = (w_a <<< 1) + w_b;
         OP_2A_MINUS_B: w_result = (w_a <<< 1) - w_b;
         OP_A_MINUS_2B: w_result = w_a - (w_b <<< 1);
         OP_A_PLUS_2B:  w_result = w_a + (w_b <<< 1);
         default:       w_result = '0;
      endcase
   end

   // Output register: reset wins, idle cycles clear the result
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_n     <= '0;
      end else if (in_valid) begin
         r_out_valid <= 1'b1;
         r_out_n     <= w_result;
      end else begin
         r_out_valid <= 1'b0;
         r_out_n     <= '0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_n     = RES_W'(r_out_n);

endmodule

// File: tb/tb_hamming_dual_decoder.sv
// Self-checking bench for hamming_dual_decoder: encoder-based reference model plus directed vectors.
module tb_hamming_dual_decoder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [6:0] code_word1;
   logic [6:0] code_word2;
   logic       out_valid;
   logic [5:0] out_n;

   int errors;
   int checks;

   logic       m_ready;
   logic       m_valid;
   logic [5:0] m_n;

   hamming_dual_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .code_word1 (code_word1),
      .code_word2 (code_word2),
      .out_valid  (out_valid),
      .out_n      (out_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build a clean code word from a 4-bit datum {x1,x2,x3,x4}
   function automatic logic [6:0] encode(input int d);
      int x1, x2, x3, x4;
      x1 = (d >> 3) & 1;
      x2 = (d >> 2) & 1;
      x3 = (d >> 1) & 1;
      x4 = d & 1;
      return 7'(((x1 ^ x2 ^ x3) << 6) | ((x1 ^ x2 ^ x4) << 5) | ((x1 ^ x3 ^ x4) << 4) | (d & 15));
   endfunction

   // Decode by search: find datum and flipped position that reproduce the received word
   function automatic void decode(input logic [6:0] cw, output int val, output int eb);
      logic [6:0] clean;
      val = 0;
      eb  = 0;
      for (int d = 0; d < 16; d++) begin
         clean = encode(d);
         if (clean == cw) begin
            val = (d >= 8) ? d - 16 : d;
            eb  = 0;
         end
         for (int p = 0; p < 7; p++) begin
            if ((clean ^ (7'd1 << p)) == cw) begin
               val = (d >= 8) ? d - 16 : d;
               eb  = ((clean >> p) & 7'd1) == 7'd1 ? 0 : 1;
            end
         end
      end
   endfunction

   function automatic logic [5:0] model_n(input logic [6:0] cw1, input logic [6:0] cw2);
      int a, b, e1, e2, r;
      decode(cw1, a, e1);
      decode(cw2, b, e2);
      case (e1 * 2 + e2)
         0:       r = 2 * a + b;
         1:       r = 2 * a - b;
         2:       r = a - 2 * b;
         default: r = a + 2 * b;
      endcase
      return 6'(r);
   endfunction

   // Reference model: expected output after each rising edge
   always @(posedge clk) begin
      m_ready <= 1'b1;
      if (rst || !in_valid) begin
         m_valid <= 1'b0;
         m_n     <= 6'd0;
      end else begin
         m_valid <= 1'b1;
         m_n     <= model_n(code_word1, code_word2);
      end
   end

   // Cycle-by-cycle compare against the model
   always @(negedge clk) begin
      if (m_ready === 1'b1) begin
         checks = checks + 1;
         if (out_valid !== m_valid || out_n !== m_n) begin
            errors = errors + 1;
            $display("FAIL model t=%0t: got valid=%b n=%0d, required valid=%b n=%0d",
                     $time, out_valid, $signed(out_n), m_valid, $signed(m_n));
         end
      end
   end

   task automatic drive(input logic v, input logic [6:0] a, input logic [6:0] b);
      @(negedge clk);
      in_valid   = v;
      code_word1 = a;
      code_word2 = b;
   endtask

   task automatic check_lit(input string name, input logic v, input logic [5:0] n);
      @(posedge clk);
      #1;
      checks = checks + 1;
      if (out_valid !== v || out_n !== n) begin
         errors = errors + 1;
         $display("FAIL %s: got valid=%b n=%b, required valid=%b n=%b", name, out_valid, out_n, v, n);
      end
   endtask

   task automatic pin_model(input string name, input logic [6:0] a, input logic [6:0] b,
                            input logic [5:0] n);
      logic [5:0] got;
      got    = model_n(a, b);
      checks = checks + 1;
      if (got !== n) begin
         errors = errors + 1;
         $display("FAIL %s: model gives %b, required %b", name, got, n);
      end
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      m_ready    = 1'b0;
      m_valid    = 1'b0;
      m_n        = 6'd0;
      rst        = 1'b1;
      in_valid   = 1'b1;
      code_word1 = 7'b1100010;
      code_word2 = 7'b1110010;

      // Pin the reference model with hand-decoded vectors
      pin_model("pin_op01", 7'b1100010, 7'b1110010, 6'd4);
      pin_model("pin_op00", 7'b0000110, 7'b0000101, 6'b010101);
      pin_model("pin_op10", 7'b1111001, 7'b0000011, 6'b101010);
      pin_model("pin_op11", 7'b1111001, 7'b0010111, 6'd6);

      // Reset held with a valid transaction presented: it must be dropped
      check_lit("reset_1", 1'b0, 6'd0);
      check_lit("reset_2", 1'b0, 6'd0);
      drive(1'b0, 7'b0, 7'b0);
      rst = 1'b0;
      check_lit("idle_after_reset", 1'b0, 6'd0);

      drive(1'b1, 7'b1100010, 7'b1110010);
      check_lit("op01", 1'b1, 6'd4);
      drive(1'b1, 7'b0000110, 7'b0000101);
      check_lit("op00_max", 1'b1, 6'b010101);
      drive(1'b1, 7'b1111001, 7'b0000011);
      check_lit("op10_min", 1'b1, 6'b101010);

      // Back-to-back: op 11 followed by op 00, then idle
      drive(1'b1, 7'b1111001, 7'b0010111);
      check_lit("b2b_first", 1'b1, 6'd6);
      drive(1'b1, 7'b0000110, 7'b0000101);
      check_lit("b2b_second", 1'b1, 6'd21);
      drive(1'b0, 7'b1111111, 7'b1111111);
      check_lit("b2b_drop", 1'b0, 6'd0);

      // Reset in the middle of traffic drops the transaction
      drive(1'b1, 7'b0000110, 7'b0000101);
      rst = 1'b1;
      check_lit("reset_midstream", 1'b0, 6'd0);
      drive(1'b0, 7'b0, 7'b0);
      rst = 1'b0;

      // Every data pair with every single-bit error position in each word
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int p = 0; p < 7; p++)
               for (int q = 0; q < 7; q++)
                  drive(1'b1, encode(a) ^ (7'd1 << p), encode(b) ^ (7'd1 << q));

      drive(1'b0, 7'b0, 7'b0);
      @(negedge clk);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hamming_dual_decoder.md
Name: hamming_dual_decoder

Overview:
- Receives two Hamming(7,4) code words per transaction, each carrying exactly one flipped bit.
- Corrects each word and extracts a 4-bit signed datum from each.
- Combines the two data with an arithmetic operation chosen by the received values of the two erroneous bits.
- Registered datapath stage with a valid handshake; sits between a code-word source and a signed-result consumer.

Parameters:
- none; all widths are fixed by the Hamming(7,4) format.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  code_word1/code_word2 are valid this cycle.
- code_word1  input  7  first received code word.
- code_word2  input  7  second received code word.
- out_valid  output  1  out_n holds a result this cycle.
- out_n  output  6  signed two's-complement result.

Behaviour:
- Code word layout, MSB first: [6]=p1, [5]=p2, [4]=p3, [3]=x1, [2]=x2, [1]=x3, [0]=x4.
- Parity equations: p1=x1^x2^x3, p2=x1^x2^x4, p3=x1^x3^x4.
- Syndrome per word: s1=p1^x1^x2^x3, s2=p2^x1^x2^x4, s3=p3^x1^x3^x4.
- Erroneous bit by {s1,s2,s3}:
  - 100=p1, 010=p2, 001=p3
  - 111=x1, 110=x2, 101=x3, 011=x4
- Syndrome 000: treated as no error; no bit is corrected and eb=0.
- Correction: invert the erroneous bit. The datum c={x1,x2,x3,x4} (corrected), interpreted as signed 4-bit, range -8..7.
- eb1 / eb2 = received (pre-correction) value of the erroneous bit in word 1 / word 2.
- Operation selected by {eb1,eb2}:
  - 00: out = 2*c1 + c2
  - 01: out = 2*c1 - c2
  - 10: out = c1 - 2*c2
  - 11: out = c1 + 2*c2
- Arithmetic: sign-extend both data to 6 bits before shift/add. All results lie in -24..23, so there is no overflow in 6 bits.
- Latency: 1 cycle. A transaction with in_valid=1 at edge N gives out_valid=1 and out_n=result after edge N; both are stable during cycle N+1.
- in_valid=0 at an edge: out_valid=0 and out_n=0 after that edge.
- Back-to-back in_valid produces back-to-back results. There is no stall or backpressure.
- Reset: rst=1 at an edge sets out_valid=0 and out_n=0. Reset has priority over in_valid, and a transaction presented during reset is dropped.
- No internal state other than the output registers.

Decomposition:
- Shared package hd_pkg holds:
  - code-word bit-position constants (P1..X4 indices);
  - the 2-bit operation encoding (OP_2A_PLUS_B, OP_2A_MINUS_B, OP_A_MINUS_2B, OP_A_PLUS_2B);
  - typedefs code_word_t (7 bits), data_t (signed 4), result_t (signed 6).
- Sub-module hamming74_corrector, instantiated twice and purely combinational:
  - input: code_word_t;
  - outputs: corrected data_t and eb.
- Top level holds the operation mux, the adder and the output registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0 and out_n=0 throughout; with rst=0, in_valid=0 the outputs stay 0.
- Op 01: code_word1=7'b1100010 (c1=3, x4 flipped, eb1=0), code_word2=7'b1110010 (c2=2, p2 flipped, eb2=1) -> next cycle out_valid=1, out_n=6'd4.
- Op 00 max: code_word1=7'b0000110 (c1=7, eb1=0), code_word2=7'b0000101 (c2=7, eb2=0) -> out_n=6'b010101 (21).
- Op 10 min: code_word1=7'b1111001 (c1=-8, x4 flipped, eb1=1), code_word2=7'b0000011 (c2=7, x2 flipped, eb2=0) -> out_n=6'b101010 (-22).
- Op 11 plus back-to-back:
  - stimulus, cycle 1: code_word1=7'b1111001, code_word2=7'b0010111 (c2=7, p3 flipped, eb2=1);
  - stimulus, cycle 2: the op-00 vector from the max case;
  - required response: out_n=6 then 21 on consecutive cycles, out_valid high both cycles, then 0 when in_valid drops.
- Exhaustive random: all 16x16 data pairs x 7x7 error positions, checked against a reference model -> zero mismatches.
